// File: rtl/derivative_buffer_reader.sv
// Burst reader: streams length symbols from the derivative buffer RAM through a 2-entry skid FIFO.
// Latency: rden to out_valid is 2 cycles. When out_ready is low, reads are throttled so the FIFO never overflows.
module derivative_buffer_reader #(
  parameter int DW    = 8,
  parameter int AW    = 8,
  parameter int DEPTH = 255
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW-1:0] length,
  output logic [AW-1:0] rdaddress,
  output logic          rden,
  input  logic [DW-1:0] q,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t        state_q;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] rem_q;
  logic          busy_q;
  logic          done_q;
  logic          pend_q;
  logic          pend_last_q;

  logic [1:0]    cnt_q, cnt_d;
  logic [DW-1:0] dat0_q, dat0_d, dat1_q, dat1_d;
  logic          last0_q, last0_d, last1_q, last1_d;

  logic          pop;
  logic          push;
  logic [1:0]    held_eff;
  logic [1:0]    occ;
  logic [AW-1:0] next_addr;

  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = dat0_q;
  assign out_last  = out_valid & last0_q;
  assign rdaddress = addr_q;
  assign busy      = busy_q;
  assign done      = done_q;

  assign pop  = out_valid & out_ready;
  assign push = pend_q;

  // The entry leaving on this edge frees its slot, which keeps one read per cycle with out_ready high.
  assign held_eff = cnt_q - {1'b0, pop};
  assign occ      = held_eff + {1'b0, pend_q};
  assign rden     = (state_q == READ) && (occ < 2'd2);

  assign next_addr = (addr_q == AW'(DEPTH - 1)) ? '0 : addr_q + 1'b1;

  always_comb begin
    cnt_d   = cnt_q;
    dat0_d  = dat0_q;
    dat1_d  = dat1_q;
    last0_d = last0_q;
    last1_d = last1_q;
    case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) begin
          dat0_d  = q;
          last0_d = pend_last_q;
        end else begin
          dat1_d  = q;
          last1_d = pend_last_q;
        end
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        dat0_d  = dat1_q;
        last0_d = last1_q;
        cnt_d   = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          dat0_d  = q;
          last0_d = pend_last_q;
        end else begin
          dat0_d  = dat1_q;
          last0_d = last1_q;
          dat1_d  = q;
          last1_d = pend_last_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= 2'd0;
      dat0_q  <= '0;
      dat1_q  <= '0;
      last0_q <= 1'b0;
      last1_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      dat0_q  <= dat0_d;
      dat1_q  <= dat1_d;
      last0_q <= last0_d;
      last1_q <= last1_d;
    end
  end

  // pend_q marks that q carries data for a read issued on the previous edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      pend_q      <= rden;
      pend_last_q <= rden && (rem_q == AW'(1));
      case (state_q)
        IDLE: begin
          if (start) begin
            if (length == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q <= READ;
              addr_q  <= base_addr;
              rem_q   <= length;
              busy_q  <= 1'b1;
            end
          end
        end
        READ: begin
          if (rden) begin
            addr_q <= next_addr;
            rem_q  <= rem_q - 1'b1;
            if (rem_q == AW'(1)) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && last0_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_derivative_buffer_reader.sv
// Scoreboard bench for derivative_buffer_reader: driver queues expected reads/symbols, negedge monitor checks them.
module tb_derivative_buffer_reader;
  localparam int DW = 8, AW = 8, DEPTH = 255;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          start;
  logic [AW-1:0] base_addr, length, rdaddress;
  logic          rden;
  logic [DW-1:0] q, out_data;
  logic          out_valid, out_ready, out_last, busy, done;

  derivative_buffer_reader #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .length(length), .rdaddress(rdaddress), .rden(rden), .q(q),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  typedef struct { logic [DW-1:0] d; logic l; } sym_t;

  logic [DW-1:0] ram [DEPTH];
  sym_t          exp_q [$];
  logic [AW-1:0] exp_addr [$];
  int cyc = 0, errors = 0, checks = 0;
  int issued = 0, xferred = 0, done_cnt = 0, done_exp = 0;
  int last_xfer_cyc = -100, zero_start_cyc = -100;
  int ready_mode = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // RAM model: one-cycle read latency, garbage when not reading.
  always @(posedge clock) begin
    if (rden && rdaddress < DEPTH) q <= ram[rdaddress];
    else q <= DW'($urandom);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void push_burst(input logic [AW-1:0] base, input int len);
    for (int i = 0; i < len; i++) begin
      int a;
      a = (int'(base) + i) % DEPTH;
      exp_addr.push_back(AW'(a));
      exp_q.push_back('{ram[a], (i == len - 1)});
    end
  endfunction

  // Monitor / scoreboard
  logic          pop_m, prev_stall = 1'b0, held_l;
  logic [DW-1:0] held_d;
  sym_t          e;
  always @(negedge clock) begin
    if (!reset_n) begin
      exp_q.delete(); exp_addr.delete();
      issued = 0; xferred = 0; prev_stall = 1'b0; last_xfer_cyc = -100;
    end else begin
      pop_m = out_valid && out_ready;
      if (cyc == last_xfer_cyc + 1) chk("done_after_last", done, 1);
      if (cyc == zero_start_cyc + 1) chk("done_after_zero_start", done, 1);
      if (done) begin
        chk("done_timing", (cyc == last_xfer_cyc + 1) || (cyc == zero_start_cyc + 1), 1);
        chk("busy_low_at_done", busy, 0);
        done_cnt++;
      end
      if (rden) begin
        chk("flow_limit", (issued - xferred - (pop_m ? 1 : 0)) < 2, 1);
        if (exp_addr.size() == 0) chk("unexpected_read", rden, 0);
        else chk("rdaddress", rdaddress, exp_addr.pop_front());
        issued++;
      end
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, held_d);
        chk("stall_last", out_last, held_l);
      end
      if (pop_m) begin
        if (exp_q.size() == 0) chk("unexpected_output", out_valid, 0);
        else begin
          e = exp_q.pop_front();
          chk("out_data", out_data, e.d);
          chk("out_last", out_last, e.l);
          if (e.l) last_xfer_cyc = cyc;
        end
        xferred++;
      end
      prev_stall = out_valid && !out_ready;
      held_d = out_data;
      held_l = out_last;
    end
  end

  // Consumer ready generator
  initial begin
    int idx = 0;
    logic [5:0] pat;
    pat = 6'b101001;  // LSB first: 1,0,0,1,0,1
    out_ready = 1'b1;
    forever begin
      @(posedge clock); #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: begin out_ready = pat[idx]; idx = (idx + 1) % 6; end
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic check_reset_vals();
    chk("rst_rden", rden, 0);
    chk("rst_rdaddress", rdaddress, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after start was sampled.
  task automatic do_start(input logic [AW-1:0] b, input logic [AW-1:0] n);
    start = 1'b1; base_addr = b; length = n;
    if (n != 0) push_burst(b, int'(n));
    else zero_start_cyc = cyc;
    done_exp++;
    @(posedge clock); #1;
    start = 1'b0;
    chk("busy_after_start", busy, (n != 0));
  endtask

  task automatic wait_done();
    int t = 0;
    while (done_cnt < done_exp && t < 400) begin @(negedge clock); t++; end
    chk("done_seen", done_cnt >= done_exp, 1);
    @(posedge clock); #1;
    chk("exp_drained", exp_q.size() + exp_addr.size(), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] vbits;
    int first_v, nv, last_v, t;
    for (int i = 0; i < DEPTH; i++) ram[i] = DW'($urandom);
    reset_n = 1'b0; start = 1'b0; base_addr = '0; length = '0;
    repeat (3) @(posedge clock);
    #1 check_reset_vals();

    // Burst at 0x10 released together with reset: consecutive reads, full throughput
    reset_n = 1'b1;
    do_start(8'h10, 8'd4);
    vbits = '0;
    for (int i = 0; i < 10; i++) begin
      if (i < 4) begin
        chk("burst_rden", rden, 1);
        chk("burst_addr", rdaddress, 8'h10 + i);
      end else if (i == 4) chk("drain_no_rden", rden, 0);
      vbits[i] = out_valid;
      @(posedge clock); #1;
    end
    first_v = -1; last_v = -1; nv = 0;
    for (int i = 0; i < 10; i++) if (vbits[i]) begin
      if (first_v < 0) first_v = i;
      last_v = i; nv++;
    end
    chk("valid_count", nv, 4);
    chk("valid_contiguous", last_v - first_v + 1, 4);
    wait_done();

    // Address wrap
    do_start(8'd253, 8'd5);
    wait_done();

    // Stalling consumer
    ready_mode = 1;
    do_start(8'h20, 8'd6);
    wait_done();
    ready_mode = 0;

    // Zero-length burst
    do_start(8'h55, 8'd0);
    chk("zero_busy", busy, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      chk("zero_rden", rden, 0);
      chk("zero_valid", out_valid, 0);
      chk("zero_busy_later", busy, 0);
    end
    wait_done();

    // Reset mid-burst, then immediate restart
    do_start(8'h80, 8'd8);
    t = 0;
    while (xferred < 3 && t < 50) begin @(posedge clock); #1; t++; end
    chk("pre_reset_progress", xferred >= 3, 1);
    reset_n = 1'b0;
    #1 check_reset_vals();
    repeat (2) begin @(posedge clock); #1; end
    reset_n = 1'b1;
    done_exp = done_cnt;
    do_start(8'h40, 8'd2);
    wait_done();

    // Start held high: one burst, next accepted in done cycle
    start = 1'b1; base_addr = 8'h30; length = 8'd3;
    push_burst(8'h30, 3); push_burst(8'h30, 3);
    done_exp += 2;
    t = 0;
    do begin @(posedge clock); #1; t++; end while (!done && t < 100);
    chk("held_start_first_done", done, 1);
    @(posedge clock); #1;
    start = 1'b0;
    chk("held_start_second_busy", busy, 1);
    wait_done();

    // Randomized bursts with random backpressure
    ready_mode = 2;
    for (int k = 0; k < 10; k++) begin
      logic [AW-1:0] b, n;
      b = AW'($urandom_range(0, DEPTH - 1));
      n = (k == 5) ? '0 : AW'($urandom_range(1, 12));
      do_start(b, n);
      wait_done();
    end
    ready_mode = 0;

    repeat (4) @(posedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
